// File: rtl/des_key_pkg.sv
//------------------------------------------------------------------------------
// des_key_pkg : DES key-schedule geometry, permutation tables, FSM states.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

package des_key_pkg;

  localparam int KEY_W    = 64;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // DES bit numbering: entry n selects DES bit n, i.e. vector bit (WIDTH - n).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [HALF_W-1:0] rol_half(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
    return (n == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                       : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] ror_half(input logic [HALF_W-1:0] x,
                                                 input logic [1:0]        n);
    return (n == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                       : {x[0], x[HALF_W-1:1]};
  endfunction

  function automatic logic [2*HALF_W-1:0] pc1_perm(input logic [KEY_W-1:0] k);
    logic [2*HALF_W-1:0] r;
    r = '0;
    for (int i = 0; i < 2*HALF_W; i++) begin
      r[2*HALF_W-1-i] = k[6'(KEY_W - PC1[i])];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_key_sched_seq_if.sv
//------------------------------------------------------------------------------
// des_key_sched_seq_if : request/subkey handshake bundle for the key scheduler.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface des_key_sched_seq_if;
  import des_key_pkg::*;

  logic                start;
  logic [KEY_W-1:0]    key;
  logic                decrypt;
  logic [SUBKEY_W-1:0] round_key;
  logic                round_key_valid;
  logic                round_ready;
  logic [3:0]          round_idx;
  logic                busy;
  logic                done;
  logic                parity_err;

  modport master (
    output start, key, decrypt, round_ready,
    input  round_key, round_key_valid, round_idx, busy, done, parity_err
  );

  modport slave (
    input  start, key, decrypt, round_ready,
    output round_key, round_key_valid, round_idx, busy, done, parity_err
  );

endinterface

`default_nettype wire

// File: rtl/des_key_sched_seq_pc2.sv
//------------------------------------------------------------------------------
// des_pc2 : combinational DES PC-2 compression, {C,D} (56 b) -> subkey (48 b).
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module des_pc2
  import des_key_pkg::*;
(
  input  wire logic [2*HALF_W-1:0] i_cd,
  output logic      [SUBKEY_W-1:0] o_subkey
);

  // PC-2 discards eight of the 56 bits by design.
  logic w_unused_cd;
  assign w_unused_cd = ^i_cd;

  always_comb begin
    o_subkey = '0;
    for (int i = 0; i < SUBKEY_W; i++) begin
      o_subkey[SUBKEY_W-1-i] = i_cd[6'(2*HALF_W - PC2[i])];
    end
  end

endmodule

`default_nettype wire

// File: rtl/des_key_sched_seq.sv
//------------------------------------------------------------------------------
// des_key_sched_seq : iterative DES subkey generator, K1..K16 or K16..K1.
// Optional key-parity checker: DES_KEY_SCHED_PARITY_CHECK_EN.  Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module des_key_sched_seq
  import des_key_pkg::*;
(
  input wire logic clk,
  input wire logic rst,
  des_key_sched_seq_if.slave bus
);

  state_t            r_state, w_state_nxt;
  logic [HALF_W-1:0] r_c, r_d, w_c_nxt, w_d_nxt;
  logic [3:0]        r_idx, w_idx_nxt;
  logic              r_dec, w_dec_nxt;
  logic              r_done, w_done_nxt;
  logic              w_load;
  logic              w_last;
  logic [2*HALF_W-1:0] w_pc1;
  logic [SUBKEY_W-1:0] w_subkey;

  assign w_pc1  = pc1_perm(bus.key);
  assign w_last = r_dec ? (r_idx == 4'd0) : (r_idx == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_idx   <= '0;
      r_dec   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_idx   <= w_idx_nxt;
      r_dec   <= w_dec_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_idx_nxt   = r_idx;
    w_dec_nxt   = r_dec;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
          w_dec_nxt   = bus.decrypt;
          // Total rotation over 16 rounds is 28, so C0/D0 already equals C16/D16.
          if (bus.decrypt) begin
            w_c_nxt   = w_pc1[2*HALF_W-1:HALF_W];
            w_d_nxt   = w_pc1[HALF_W-1:0];
            w_idx_nxt = 4'd15;
          end else begin
            w_c_nxt   = rol_half(w_pc1[2*HALF_W-1:HALF_W], SHIFT_SCHED[0]);
            w_d_nxt   = rol_half(w_pc1[HALF_W-1:0], SHIFT_SCHED[0]);
            w_idx_nxt = 4'd0;
          end
        end
      end
      ST_RUN: begin
        if (bus.round_ready) begin
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else if (r_dec) begin
            w_c_nxt   = ror_half(r_c, SHIFT_SCHED[r_idx]);
            w_d_nxt   = ror_half(r_d, SHIFT_SCHED[r_idx]);
            w_idx_nxt = r_idx - 4'd1;
          end else begin
            w_c_nxt   = rol_half(r_c, SHIFT_SCHED[r_idx + 4'd1]);
            w_d_nxt   = rol_half(r_d, SHIFT_SCHED[r_idx + 4'd1]);
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  des_pc2 u_pc2 (
    .i_cd     ({r_c, r_d}),
    .o_subkey (w_subkey)
  );

  assign bus.round_key_valid = (r_state == ST_RUN);
  assign bus.busy            = (r_state == ST_RUN);
  assign bus.round_key       = (r_state == ST_RUN) ? w_subkey : '0;
  assign bus.round_idx       = r_idx;
  assign bus.done            = r_done;

`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
  logic r_parity_err;
  logic w_key_par_bad;

  always_comb begin
    w_key_par_bad = 1'b0;
    for (int b = 0; b < KEY_W/8; b++) begin
      w_key_par_bad = w_key_par_bad | ~(^bus.key[8*b +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_load) begin
      r_parity_err <= w_key_par_bad;
    end
  end

  assign bus.parity_err = r_parity_err;
`else
  // Parity bits of the key are dropped by PC-1 and have no other consumer here.
  logic w_unused_key;
  assign w_unused_key   = ^bus.key | w_load;
  assign bus.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_des_key_sched_seq.sv
//------------------------------------------------------------------------------
// tb_des_key_sched_seq : scoreboard bench for the iterative DES key scheduler.
//------------------------------------------------------------------------------
`default_nettype none

module tb_des_key_sched_seq;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K2   = 48'h79AED9DBC9E5;
  localparam logic [47:0] K15  = 48'hBF918D3D3F0A;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4 };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32 };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;

  des_key_sched_seq_if bus();

  des_key_sched_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] k;
    logic [3:0]  idx;
  } exp_t;

  int          n_checks = 0;
  int          n_errs   = 0;
  exp_t        q[$];
  logic [47:0] obs[$];
  logic [47:0] enc_seq[$];
  bit          rand_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] rotl(input logic [27:0] x, input int s);
    logic [55:0] t;
    t = {x, x};
    return t[55-s -: 28];
  endfunction

  // Subkey n (1..16): PC-1, rotate both halves by the cumulative shift, PC-2.
  function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int n);
    logic [55:0] cd;
    logic [47:0] r;
    int tot;
    tot = 0;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
    for (int j = 0; j < n; j++) tot += SH_T[j];
    cd = {rotl(cd[55:28], tot), rotl(cd[27:0], tot)};
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_T[i]];
    return r;
  endfunction

  function automatic bit exp_par(input logic [63:0] k);
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
    for (int b = 0; b < 8; b++) begin
      if (($countones(k[8*b +: 8]) % 2) == 0) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  initial begin
    bus.round_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.round_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples on the falling edge, where a visible valid&ready means
  // an accept at the coming rising edge.
  bit          exp_done = 1'b0;
  bit          hold     = 1'b0;
  logic [47:0] held_k;
  logic [3:0]  held_i;
  int          nacc     = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_done = 1'b0;
      hold     = 1'b0;
      nacc     = 0;
    end else begin
      chk("done", 64'(bus.done), 64'(exp_done));
      exp_done = 1'b0;
      if (bus.round_key_valid) begin
        if (hold) begin
          chk("stall_key", 64'(bus.round_key), 64'(held_k));
          chk("stall_idx", 64'(bus.round_idx), 64'(held_i));
        end
        if (bus.round_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_accept", 64'(1), 64'(0));
          end else begin
            e = q.pop_front();
            chk("subkey", 64'(bus.round_key), 64'(e.k));
            chk("round_idx", 64'(bus.round_idx), 64'(e.idx));
          end
          obs.push_back(bus.round_key);
          nacc++;
          if (nacc == 16) begin
            exp_done = 1'b1;
            nacc     = 0;
          end
          hold = 1'b0;
        end else begin
          hold   = 1'b1;
          held_k = bus.round_key;
          held_i = bus.round_idx;
        end
      end else begin
        hold = 1'b0;
        chk("key_zero_when_invalid", 64'(bus.round_key), 64'(0));
      end
    end
  end

  // Called one step after a rising edge with the scheduler idle.
  task automatic start_sched(input logic [63:0] k, input bit dec);
    int n;
    bus.key     = k;
    bus.decrypt = dec;
    bus.start   = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n = dec ? 16 - i : i + 1;
      q.push_back('{ref_subkey(k, n), 4'(n - 1)});
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("first_valid", 64'(bus.round_key_valid), 64'(1));
    chk("busy_after_start", 64'(bus.busy), 64'(1));
    chk("parity_err_load", 64'(bus.parity_err), 64'(exp_par(k)));
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (!bus.done && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done_seen"}, 64'(bus.done), 64'(1));
    chk({name, "_queue_drained"}, 64'(q.size()), 64'(0));
    @(posedge clk);
    #1;
    chk({name, "_idle_after_done"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic wait_idx(input logic [3:0] want);
    int t;
    t = 0;
    while (!(bus.round_key_valid && bus.round_idx == want) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("reach_idx", 64'(bus.round_idx), 64'(want));
  endtask

  initial begin
    logic [63:0] rk;
    bit          rd;
    bus.start   = 1'b0;
    bus.key     = '0;
    bus.decrypt = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.round_key_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_parity", 64'(bus.parity_err), 64'(0));
    chk("rst_key", 64'(bus.round_key), 64'(0));
    chk("rst_idx", 64'(bus.round_idx), 64'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Encrypt, ready held high
    obs.delete();
    start_sched(KEY, 1'b0);
    wait_done("enc");
    chk("enc_count", 64'(obs.size()), 64'(16));
    chk("enc_K1", 64'(obs[0]), 64'(K1));
    chk("enc_K2", 64'(obs[1]), 64'(K2));
    chk("enc_K16", 64'(obs[15]), 64'(K16));
    enc_seq = obs;

    // Decrypt, same key
    obs.delete();
    start_sched(KEY, 1'b1);
    wait_done("dec");
    chk("dec_count", 64'(obs.size()), 64'(16));
    chk("dec_first", 64'(obs[0]), 64'(K16));
    chk("dec_second", 64'(obs[1]), 64'(K15));
    chk("dec_last", 64'(obs[15]), 64'(K1));
    for (int i = 0; i < 16; i++) chk("dec_reversed", 64'(obs[i]), 64'(enc_seq[15-i]));

    // Backpressure
    rand_ready = 1'b1;
    obs.delete();
    start_sched(KEY, 1'b0);
    wait_done("bp");
    rand_ready = 1'b0;
    chk("bp_count", 64'(obs.size()), 64'(16));
    for (int i = 0; i < 16; i++) chk("bp_same_seq", 64'(obs[i]), 64'(enc_seq[i]));

    // start while busy is ignored
    start_sched(KEY, 1'b0);
    wait_idx(4'd5);
    bus.key     = 64'hFFFF_0000_1234_5678;
    bus.decrypt = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("busy_start");

    // start coincident with the final accept is ignored
    start_sched(KEY, 1'b0);
    wait_idx(4'd15);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_restart_on_last", 64'(bus.round_key_valid), 64'(0));
    end

    // Reset mid-schedule
    start_sched(KEY, 1'b0);
    wait_idx(4'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", 64'(bus.round_key_valid), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_key", 64'(bus.round_key), 64'(0));
    chk("abort_idx", 64'(bus.round_idx), 64'(0));
    chk("abort_parity", 64'(bus.parity_err), 64'(0));
    q.delete();
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    obs.delete();
    start_sched(KEY, 1'b0);
    wait_done("after_reset");
    for (int i = 0; i < 16; i++) chk("after_reset_seq", 64'(obs[i]), 64'(enc_seq[i]));

    // Parity: bad key, then a good key
    start_sched(KEY ^ 64'h1, 1'b0);
    wait_done("bad_parity");
    chk("parity_after_done", 64'(bus.parity_err), 64'(exp_par(KEY ^ 64'h1)));
    start_sched(KEY, 1'b0);
    wait_done("good_parity");
    chk("parity_cleared", 64'(bus.parity_err), 64'(0));

    // Random keys, directions and ready patterns
    for (int r = 0; r < 6; r++) begin
      rk         = {$urandom, $urandom};
      rd         = 1'($urandom_range(0, 1));
      rand_ready = 1'($urandom_range(0, 1));
      start_sched(rk, rd);
      wait_done("random");
    end
    rand_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errs);
    $fatal(1);
  end

endmodule

`default_nettype wire
